// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared widths, fetch FSM encoding and fetch buffer entry layout
//
// Purpose: common definitions for the PC fetch unit slice.
//   PC_W  : program counter / ROM address width
//   OPC_W : opcode field width (top bits of the instruction)
//   fetch_state_e : IDLE / RUN / HALTED (HALTED reachable only with PCF_HALT_EN)
//   Fetch buffer entry layout is {pc, instr}: pc in the upper PC_W bits.
package pc_pkg;

  localparam int PC_W  = 8;
  localparam int OPC_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

  // Width of one fetch buffer entry {pc, instr}.
  function automatic int entry_w(input int instr_w);
    return PC_W + instr_w;
  endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// rtl/pc_fetch_unit_if.sv - instruction ROM and decode handshake bundle
//
// Purpose: groups the ROM port and the valid/ready decode stream.
//   imem_addr  : ROM address (fetch -> ROM)
//   imem_rdata : ROM data, one cycle after the address (ROM -> fetch)
//   if_valid   : buffer head valid (fetch -> decode)
//   if_ready   : decode accepts head (decode -> fetch)
//   if_instr   : head instruction (fetch -> decode)
//   if_pc      : PC of head instruction (fetch -> decode)
// Modports: master = fetch unit side, slave = ROM/decode side.
interface pc_fetch_unit_if #(
  parameter int INSTR_W = 16
) ();
  import pc_pkg::*;

  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               if_valid;
  logic               if_ready;
  logic [INSTR_W-1:0] if_instr;
  logic [PC_W-1:0]    if_pc;

  modport master (
    output imem_addr,
    input  imem_rdata,
    output if_valid,
    input  if_ready,
    output if_instr,
    output if_pc
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    input  if_valid,
    output if_ready,
    input  if_instr,
    input  if_pc
  );

endinterface

// File: rtl/pcf_fifo.sv
// rtl/pcf_fifo.sv - synchronous fetch buffer FIFO with flush and occupancy count
//
// Purpose: holds fetched {pc, instr} entries in program order.
//   clk, rst      : clock, asynchronous active-high reset
//   flush_i       : empty the FIFO (wins over a same-cycle push)
//   push_i        : write push_data_i (accepted when not full, or full with a pop)
//   push_data_i   : entry to write
//   pop_i         : remove head (ignored when empty)
//   head_data_o   : head entry, zero when empty
//   valid_o       : FIFO not empty
//   count_o       : number of stored entries
module pcf_fifo #(
  parameter int W     = 24,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic [W-1:0]                 push_data_i,
  input  logic                         pop_i,
  output logic [W-1:0]                 head_data_o,
  output logic                         valid_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  // Pointer increment that wraps for non-power-of-two depths.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop_i && (count_q != '0);
  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_push && !do_pop) count_d = count_q + 1'b1;
      else if (!do_push && do_pop) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign valid_o     = (count_q != '0);
  assign head_data_o = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o     = count_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter owner and instruction fetch front end
//
// Purpose: issues sequential ROM fetches from the 8-bit PC, buffers responses
// with their PC and presents them to decode over valid/ready. Redirects via
// pc_write flush the buffer and drop the in-flight response.
// Optional feature macro: PCF_HALT_EN (HALT opcode stops fetching).
//   clk, rst        : clock, asynchronous active-high reset
//   pc_write        : redirect strobe
//   overwrite_data  : redirect target PC
//   halted          : high in HALTED state (0 without PCF_HALT_EN)
//   bus (master)    : imem_addr/imem_rdata ROM port, if_valid/if_ready/if_instr/if_pc
module pc_fetch_unit
  import pc_pkg::*;
#(
  parameter int              INSTR_W     = 16,
  parameter int              FIFO_DEPTH  = 2,
  parameter logic [OPC_W-1:0] HALT_OPCODE = 4'hF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pc_write,
  input  logic [PC_W-1:0]  overwrite_data,
  output logic             halted,
  pc_fetch_unit_if.master  bus
);

  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int EW = entry_w(INSTR_W);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] issued_pc_q;
  logic            inflight_q, inflight_d;

  logic            pop, push, issue, halt_hit;
  logic [CW-1:0]   count;
  logic [CW:0]     occ_after;
  logic [EW-1:0]   head;

  assign pop = bus.if_valid & bus.if_ready;

  // Occupancy once this cycle's capture and pop have settled; issuing only
  // below depth guarantees the response two cycles out always has a slot.
  assign occ_after = {1'b0, count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
  assign issue     = (state_q == ST_RUN) && !pc_write
                     && (occ_after < (CW+1)'(FIFO_DEPTH));

  // A redirect in the capture cycle kills the response; so does HALTED.
  assign push = inflight_q && !pc_write && (state_q != ST_HALTED);

`ifdef PCF_HALT_EN
  assign halt_hit = push && (bus.imem_rdata[INSTR_W-1 -: OPC_W] == HALT_OPCODE);
  assign halted   = (state_q == ST_HALTED);
`else
  logic unused_halt_cfg;
  assign unused_halt_cfg = ^HALT_OPCODE;
  assign halt_hit = 1'b0;
  assign halted   = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inflight_d = issue;
    if (issue) pc_d = pc_q + 1'b1;
    case (state_q)
      ST_IDLE:   state_d = ST_RUN;
      ST_RUN:    if (halt_hit) state_d = ST_HALTED;
      ST_HALTED: if (pc_write) state_d = ST_RUN;
      default:   state_d = ST_IDLE;
    endcase
    // Redirect overrides both the sequential increment and the halt entry.
    if (pc_write) begin
      pc_d = overwrite_data;
      if (state_q != ST_IDLE) state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pc_q        <= '0;
      issued_pc_q <= '0;
      inflight_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      issued_pc_q <= pc_q;
      inflight_q  <= inflight_d;
    end
  end

  pcf_fifo #(
    .W     (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (pc_write),
    .push_i      (push),
    .push_data_i ({issued_pc_q, bus.imem_rdata}),
    .pop_i       (pop),
    .head_data_o (head),
    .valid_o     (bus.if_valid),
    .count_o     (count)
  );

  assign bus.imem_addr = pc_q;
  assign bus.if_pc     = head[EW-1 -: PC_W];
  assign bus.if_instr  = head[INSTR_W-1:0];

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed self-checking bench for pc_fetch_unit
module tb_pc_fetch_unit;
  import pc_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       pc_write;
  logic [7:0] overwrite_data;
  logic       halted;
  int         total = 0;
  int         bad = 0;
  int         w;
  logic [15:0] rom [256];

  always #5 clk = ~clk;

  pc_fetch_unit_if #(.INSTR_W(16)) bus ();

  pc_fetch_unit #(
    .INSTR_W     (16),
    .FIFO_DEPTH  (2),
    .HALT_OPCODE (4'hF)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_write       (pc_write),
    .overwrite_data (overwrite_data),
    .halted         (halted),
    .bus            (bus)
  );

  // Synchronous ROM: data for the address seen at an edge appears after it.
  always @(posedge clk) bus.imem_rdata <= rom[bus.imem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Waits (bounded) for a handshake, checks the head, then lets it pop.
  task automatic expect_next(input string tag, input logic [7:0] epc, output int waited);
    waited = 0;
    while (!(bus.if_valid === 1'b1 && bus.if_ready === 1'b1) && waited < 20) begin
      step();
      waited++;
    end
    chk({tag, " valid"}, {31'b0, bus.if_valid}, 32'd1);
    chk({tag, " pc"}, {24'b0, bus.if_pc}, {24'b0, epc});
    chk({tag, " instr"}, {16'b0, bus.if_instr}, {16'b0, rom[epc]});
    step();
  endtask

  task automatic redirect(input logic [7:0] target);
    pc_write = 1'b1;
    overwrite_data = target;
    step();
    pc_write = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'h1000 + 16'(i);
    rst = 1'b1;
    pc_write = 1'b0;
    overwrite_data = 8'h00;
    bus.if_ready = 1'b0;
    repeat (3) step();

    chk("rst valid", {31'b0, bus.if_valid}, 32'd0);
    chk("rst halted", {31'b0, halted}, 32'd0);
    chk("rst addr", {24'b0, bus.imem_addr}, 32'h00);
    chk("rst instr", {16'b0, bus.if_instr}, 32'h0);
    chk("rst pc", {24'b0, bus.if_pc}, 32'h00);

    // Test 1: startup latency and back-to-back delivery
    rst = 1'b0;
    bus.if_ready = 1'b1;
    step();
    chk("t1 addr c1", {24'b0, bus.imem_addr}, 32'h00);
    chk("t1 valid c1", {31'b0, bus.if_valid}, 32'd0);
    step();
    chk("t1 addr c2", {24'b0, bus.imem_addr}, 32'h01);
    chk("t1 valid c2", {31'b0, bus.if_valid}, 32'd0);
    step();
    chk("t1 addr c3", {24'b0, bus.imem_addr}, 32'h02);
    chk("t1 valid c3", {31'b0, bus.if_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      expect_next("t1 seq", 8'(i), w);
      chk("t1 gap", w, 0);
    end

    // Test 2a: stall with 0x05/0x06 buffered, 0x07 pending
    bus.if_ready = 1'b0;
    step();
    chk("t2 hold addr a", {24'b0, bus.imem_addr}, 32'h07);
    repeat (5) step();
    chk("t2 hold addr b", {24'b0, bus.imem_addr}, 32'h07);
    chk("t2 hold head", {24'b0, bus.if_pc}, 32'h05);

    // Test 3: redirect while full
    redirect(8'h40);
    chk("t3 flush valid", {31'b0, bus.if_valid}, 32'd0);
    chk("t3 new addr", {24'b0, bus.imem_addr}, 32'h40);
    bus.if_ready = 1'b1;
    expect_next("t3 first", 8'h40, w);
    expect_next("t3 second", 8'h41, w);

    // Test 2b: stall mid-stream then resume, nothing lost or repeated
    bus.if_ready = 1'b0;
    repeat (6) step();
    chk("t2b hold addr", {24'b0, bus.imem_addr}, 32'h44);
    chk("t2b hold head", {24'b0, bus.if_pc}, 32'h42);
    bus.if_ready = 1'b1;
    for (int i = 8'h42; i < 8'h48; i++) expect_next("t2b seq", 8'(i), w);

    // Test 4: wrap through 0xFF
    redirect(8'hFE);
    chk("t4 flush valid", {31'b0, bus.if_valid}, 32'd0);
    expect_next("t4 fe", 8'hFE, w);
    expect_next("t4 ff", 8'hFF, w);
    expect_next("t4 00", 8'h00, w);
    expect_next("t4 01", 8'h01, w);

    // Test 5: redirect coinciding with a pop and an in-flight response
    chk("t5 head valid", {31'b0, bus.if_valid}, 32'd1);
    chk("t5 head pc", {24'b0, bus.if_pc}, 32'h02);
    redirect(8'h80);
    chk("t5 flush valid", {31'b0, bus.if_valid}, 32'd0);
    expect_next("t5 target", 8'h80, w);
    expect_next("t5 next", 8'h81, w);

    // Test 6: HALT opcode at 0x03
    rom[3] = 16'hF000;
    redirect(8'h00);
    for (int i = 0; i < 4; i++) expect_next("t6 seq", 8'(i), w);
`ifdef PCF_HALT_EN
    chk("t6 halted", {31'b0, halted}, 32'd1);
    repeat (3) step();
    chk("t6 drained", {31'b0, bus.if_valid}, 32'd0);
    chk("t6 no issue", {24'b0, bus.imem_addr}, 32'h05);
    chk("t6 still halted", {31'b0, halted}, 32'd1);
    redirect(8'h10);
    chk("t6 resumed", {31'b0, halted}, 32'd0);
    expect_next("t6 restart", 8'h10, w);
`else
    chk("t6 not halted", {31'b0, halted}, 32'd0);
    expect_next("t6 past halt", 8'h04, w);
    redirect(8'h10);
    expect_next("t6 restart", 8'h10, w);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
